// File: rtl/floyd_spi_tx_slave_pkg.sv
// floyd_spi_tx_slave_pkg: shared FSM states and synchroniser depth for the MISO transmitter
package floyd_spi_tx_slave_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_FETCH, TX_REQ, TX_SHIFT, TX_DONE} tx_state_t;
    localparam int SPI_SYNC_STAGES = 2;
endpackage

// File: rtl/floyd_spi_tx_slave_spi_edge_sync.sv
// spi_edge_sync: synchronises an asynchronous SPI line and emits one-clk rise/fall pulses
//   in:  clk, rst, async_in
//   out: level (synchronised), rise, fall (valid SYNC_STAGES+1 clk after the pin changes)
module spi_edge_sync
    import floyd_spi_tx_slave_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;
endmodule

// File: rtl/floyd_spi_tx_slave.sv
// floyd_spi_tx_slave: SPI-slave MISO transmitter streaming a dithered frame from the result RAM
//   in:  clk, rst, start, rd_data (1 clk after rd_addr), SPI_CLK, SPI_CS (async, mode 0, CS active low)
//   out: rd_addr, SPI_MISO, SPI_MISO_oe, request_flag, busy, done
module floyd_spi_tx_slave
    import floyd_spi_tx_slave_pkg::*;
#(
    parameter int RGB_SIZE         = 8,
    parameter int IMAGE_SIZE       = 16,
    parameter int IMAGE_ADDR_WIDTH = 4,
    parameter int SYNC_STAGES      = SPI_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [IMAGE_ADDR_WIDTH-1:0] rd_addr,
    input  logic [RGB_SIZE-1:0]         rd_data,
    input  logic                        SPI_CLK,
    input  logic                        SPI_CS,
    output logic                        SPI_MISO,
    output logic                        SPI_MISO_oe,
    output logic                        request_flag,
    output logic                        busy,
    output logic                        done
);
    localparam int BW = $clog2(RGB_SIZE) + 1;
    localparam int PW = IMAGE_ADDR_WIDTH + 1;
    localparam logic [BW-1:0] BITS   = BW'(RGB_SIZE);
    localparam logic [PW-1:0] PIXELS = PW'(IMAGE_SIZE);

    tx_state_t         state_q, state_d;
    logic [PW-1:0]     addr_q, addr_d;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [RGB_SIZE-1:0] shift_q, shift_d, shadow_q, shadow_d, next_q, next_d;
    logic              next_vld_q, next_vld_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d, busy_q, busy_d, done_q, done_d, oe_q, oe_d;
    logic              clk_lvl, clk_rise, clk_fall, cs_lvl, cs_rise, cs_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
        .clk(clk), .rst(rst), .async_in(SPI_CLK),
        .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
    );

    // CS idles high, so its synchroniser resets high to avoid a phantom edge
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .async_in(SPI_CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pix_cnt_d  = pix_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        next_d     = next_q;
        next_vld_d = next_vld_q;
        pend_d     = pend_q;
        req_d      = req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            TX_IDLE: if (start) begin
                state_d    = TX_FETCH;
                addr_d     = '0;
                pix_cnt_d  = '0;
                bit_cnt_d  = '0;
                next_vld_d = 1'b0;
                pend_d     = 1'b0;
                busy_d     = 1'b1;
            end
            // first cycle lets the RAM register the address, second captures its data
            TX_FETCH: if (pend_q) begin
                shift_d  = rd_data;
                shadow_d = rd_data;
                addr_d   = addr_q + 1'b1;
                pend_d   = 1'b0;
                req_d    = 1'b1;
                state_d  = TX_REQ;
            end else begin
                pend_d = 1'b1;
            end
            TX_REQ: if (cs_fall) begin
                req_d   = 1'b0;
                state_d = TX_SHIFT;
            end
            TX_SHIFT: begin
                if (pend_q) begin
                    next_d     = rd_data;
                    next_vld_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    pend_d     = 1'b0;
                end else if (!next_vld_q && addr_q < PIXELS) begin
                    pend_d = 1'b1;
                end
                if (cs_rise && bit_cnt_q < BITS) begin
                    // aborted byte: rewind so the next CS low resends it from the MSB
                    shift_d   = shadow_q;
                    bit_cnt_d = '0;
                end else if (clk_rise && !cs_lvl) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BITS - 1'b1) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (pix_cnt_q == PIXELS - 1'b1) state_d = TX_DONE;
                    end
                end else if (clk_fall && !cs_lvl) begin
                    if (bit_cnt_q == BITS) begin
                        shift_d    = next_q;
                        shadow_d   = next_q;
                        bit_cnt_d  = '0;
                        next_vld_d = 1'b0;
                    end else if (bit_cnt_q != '0) begin
                        shift_d = shift_q << 1;
                    end
                end
            end
            TX_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
        oe_d = (state_d == TX_SHIFT) && !cs_lvl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            addr_q     <= '0;
            pix_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            shadow_q   <= '0;
            next_q     <= '0;
            next_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pix_cnt_q  <= pix_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            next_q     <= next_d;
            next_vld_q <= next_vld_d;
            pend_q     <= pend_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            oe_q       <= oe_d;
        end
    end

    assign rd_addr      = addr_q[IMAGE_ADDR_WIDTH-1:0];
    assign SPI_MISO     = (state_q == TX_SHIFT) && !cs_lvl && shift_q[RGB_SIZE-1];
    assign SPI_MISO_oe  = oe_q;
    assign request_flag = req_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_floyd_spi_tx_slave.sv
// tb_floyd_spi_tx_slave: scoreboard bench acting as SPI host and result RAM
module tb_floyd_spi_tx_slave;
    import floyd_spi_tx_slave_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       SPI_CLK = 1'b0;
    logic       SPI_CS = 1'b1;
    logic       SPI_MISO, SPI_MISO_oe, request_flag, busy, done;

    logic [7:0] ram [16];
    logic [7:0] exp_q [$];
    int         vec = 0;
    int         err = 0;
    int         done_cnt = 0;

    floyd_spi_tx_slave dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MISO(SPI_MISO), .SPI_MISO_oe(SPI_MISO_oe),
        .request_flag(request_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= ram[rd_addr];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    endtask

    task automatic xfer(input int nbits, output logic [7:0] b);
        b = 8'h00;
        SPI_CS = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 && nbits == 8) begin
                vec++;
                if (SPI_MISO_oe !== 1'b1) begin
                    err++;
                    $display("FAIL miso_oe: got %b want 1", SPI_MISO_oe);
                end
            end
            b = {b[6:0], SPI_MISO};
            SPI_CLK = 1'b1;
            repeat (4) @(negedge clk);
            SPI_CLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        SPI_CS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic start_frame();
        bit seen = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(ram[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            seen = (request_flag === 1'b1);
        end
        vec++;
        if (!seen) begin
            err++;
            $display("FAIL request_flag: got %b want 1 within 3 clk", request_flag);
        end
    endtask

    task automatic read_bytes(input int n);
        logic [7:0] b, e;
        for (int i = 0; i < n; i++) begin
            xfer(8, b);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            vec++;
            if (b !== e) begin
                err++;
                $display("FAIL pixel: got %h want %h", b, e);
            end
        end
    endtask

    task automatic finish_frame(input int d0);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (busy !== 1'b0) begin
            err++;
            $display("FAIL busy_fall: got %b want 0", busy);
        end
        vec++;
        if (done_cnt - d0 != 1) begin
            err++;
            $display("FAIL done_count: got %0d want 1", done_cnt - d0);
        end
        vec++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL leftover: got %0d pixels pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vec += 6;
        if (rd_addr !== 4'h0) begin err++; $display("FAIL rst_rd_addr: got %h want 0", rd_addr); end
        if (SPI_MISO !== 1'b0) begin err++; $display("FAIL rst_miso: got %b want 0", SPI_MISO); end
        if (SPI_MISO_oe !== 1'b0) begin err++; $display("FAIL rst_oe: got %b want 0", SPI_MISO_oe); end
        if (request_flag !== 1'b0) begin err++; $display("FAIL rst_req: got %b want 0", request_flag); end
        if (busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
        if (dut.state_q !== TX_IDLE) begin err++; $display("FAIL rst_state: got %0d want IDLE", dut.state_q); end
    endtask

    task automatic test_frame();
        int d0;
        fill_ramp();
        d0 = done_cnt;
        start_frame();
        read_bytes(16);
        finish_frame(d0);
    endtask

    task automatic test_msb_first();
        int d0;
        logic [7:0] b, e;
        logic [7:0] want = 8'b1010_0101;
        fill_ramp();
        ram[0] = 8'hA5;
        d0 = done_cnt;
        start_frame();
        xfer(8, b);
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (b[7-i] !== want[7-i]) begin
                err++;
                $display("FAIL msb_bit%0d: got %b want %b", i, b[7-i], want[7-i]);
            end
        end
        vec++;
        if (b !== e) begin err++; $display("FAIL msb_byte: got %h want %h", b, e); end
        read_bytes(15);
        finish_frame(d0);
    endtask

    task automatic test_abort();
        int d0;
        logic [7:0] b;
        fill_ramp();
        ram[2] = 8'h3C;
        d0 = done_cnt;
        start_frame();
        read_bytes(2);
        xfer(3, b);
        vec++;
        if (busy !== 1'b1) begin err++; $display("FAIL abort_busy: got %b want 1", busy); end
        read_bytes(14);
        finish_frame(d0);
    endtask

    task automatic test_start_while_busy();
        int d0;
        fill_ramp();
        d0 = done_cnt;
        start_frame();
        read_bytes(5);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if (request_flag !== 1'b0 || busy !== 1'b1) begin
            err++;
            $display("FAIL busy_start: got req=%b busy=%b want req=0 busy=1", request_flag, busy);
        end
        read_bytes(11);
        finish_frame(d0);
    endtask

    task automatic test_rst_mid_frame();
        int d0;
        logic [7:0] b;
        fill_ramp();
        start_frame();
        read_bytes(7);
        xfer(4, b);
        d0 = done_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec += 3;
        if (request_flag !== 1'b0) begin err++; $display("FAIL rstmid_req: got %b want 0", request_flag); end
        if (busy !== 1'b0) begin err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (rd_addr !== 4'h0) begin err++; $display("FAIL rstmid_addr: got %h want 0", rd_addr); end
        repeat (20) @(negedge clk);
        vec++;
        if (done_cnt != d0) begin err++; $display("FAIL rstmid_done: got %0d pulses want 0", done_cnt - d0); end
        d0 = done_cnt;
        start_frame();
        read_bytes(16);
        finish_frame(d0);
    endtask

    initial begin
        fill_ramp();
        test_reset();
        test_frame();
        test_msb_first();
        test_abort();
        test_start_while_busy();
        test_rst_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
